// File: rtl/alsu_input_conditioner.sv
// Switch/button front-end for the ALSU board: two-flop sync, per-bit debounce, and a
// LOAD-button FSM that commits the debounced switch set to registered outputs.
module alsu_input_conditioner #(
    parameter int unsigned DB_CYCLES      = 1000000,
    parameter int unsigned HOLDOFF_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] A_sw,
    input  logic [2:0] B_sw,
    input  logic [2:0] opcode_sw,
    input  logic [6:0] ctrl_sw,
    input  logic       load_btn,
    output logic [2:0] A_out,
    output logic [2:0] B_out,
    output logic [2:0] opcode_out,
    output logic [6:0] ctrl_out,
    output logic       load_pulse,
    output logic       sw_stable
);

    localparam int unsigned NBITS = 17;
    localparam int unsigned NSW   = 16;
    localparam int unsigned DB_W  = $clog2(DB_CYCLES);
    localparam int unsigned HO_W  = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);
    localparam logic [HO_W-1:0] HO_MAX = HO_W'(HOLDOFF_CYCLES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    // Bit 16 is the button; bits 15:0 are the switches in output order.
    logic [NBITS-1:0] raw;
    logic [NBITS-1:0] sync1_q, sync2_q;
    logic [NBITS-1:0] db_q, db_d;
    logic [DB_W-1:0]  cnt_q [NBITS];
    logic [DB_W-1:0]  cnt_d [NBITS];

    logic [1:0]      state_q, state_d;
    logic [HO_W-1:0] ho_cnt_q, ho_cnt_d;
    logic            commit;
    logic            db_btn;

    assign raw    = {load_btn, ctrl_sw, opcode_sw, B_sw, A_sw};
    assign db_btn = db_q[NBITS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < NBITS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_MAX) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_q <= '0;
            for (int i = 0; i < NBITS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q <= db_d;
            for (int i = 0; i < NBITS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        sw_stable = 1'b1;
        for (int i = 0; i < NSW; i++) begin
            if (cnt_q[i] != '0) begin
                sw_stable = 1'b0;
            end
        end
    end

    // Only the IDLE->PRESSED transition commits; a press still held when holdoff
    // expires lands in PRESSED without a second commit.
    always_comb begin
        state_d  = state_q;
        ho_cnt_d = ho_cnt_q;
        commit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (db_btn) begin
                    state_d = ST_PRESSED;
                    commit  = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!db_btn) begin
                    state_d  = ST_HOLDOFF;
                    ho_cnt_d = '0;
                end
            end
            ST_HOLDOFF: begin
                if (ho_cnt_q == HO_MAX) begin
                    state_d = db_btn ? ST_PRESSED : ST_IDLE;
                end else begin
                    ho_cnt_d = ho_cnt_q + HO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ho_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ho_cnt_q <= ho_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            A_out      <= '0;
            B_out      <= '0;
            opcode_out <= '0;
            ctrl_out   <= '0;
            load_pulse <= 1'b0;
        end else begin
            load_pulse <= commit;
            if (commit) begin
                A_out      <= db_q[2:0];
                B_out      <= db_q[5:3];
                opcode_out <= db_q[8:6];
                ctrl_out   <= db_q[15:9];
            end
        end
    end

endmodule

// File: tb/tb_alsu_input_conditioner.sv
// Directed bench for alsu_input_conditioner with short debounce/holdoff windows.
module tb_alsu_input_conditioner;

    localparam int unsigned DB = 4;
    localparam int unsigned HO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] A_sw, B_sw, opcode_sw;
    logic [6:0] ctrl_sw;
    logic       load_btn;
    logic [2:0] A_out, B_out, opcode_out;
    logic [6:0] ctrl_out;
    logic       load_pulse, sw_stable;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    alsu_input_conditioner #(
        .DB_CYCLES      (DB),
        .HOLDOFF_CYCLES (HO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .A_sw       (A_sw),
        .B_sw       (B_sw),
        .opcode_sw  (opcode_sw),
        .ctrl_sw    (ctrl_sw),
        .load_btn   (load_btn),
        .A_out      (A_out),
        .B_out      (B_out),
        .opcode_out (opcode_out),
        .ctrl_out   (ctrl_out),
        .load_pulse (load_pulse),
        .sw_stable  (sw_stable)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load_pulse === 1'b1) pulses++;
    end

    typedef struct {
        logic [2:0] a, b, op;
        logic [6:0] ctrl;
        logic       use_late;
        logic [2:0] late_a;
        logic [2:0] exp_a, exp_b, exp_op;
        logic [6:0] exp_ctrl;
    } vec_t;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_pulse(input string name, input int limit, output int lat);
        lat = -1;
        for (int i = 1; i <= limit; i++) begin
            step(1);
            if (load_pulse === 1'b1) begin
                lat = i;
                break;
            end
        end
        total++;
        if (lat < 0) begin
            bad++;
            $display("FAIL %s: got no load_pulse expected one within %0d cycles", name, limit);
        end
    endtask

    function automatic logic [17:0] out_vec();
        return {A_out, B_out, opcode_out, ctrl_out, load_pulse, sw_stable};
    endfunction

    initial begin
        vec_t vecs[4];
        int   lat;
        int   p0;

        vecs[0] = '{3'd1, 3'd6, 3'd7, 7'h55, 1'b0, 3'd0, 3'd1, 3'd6, 3'd7, 7'h55};
        vecs[1] = '{3'd0, 3'd0, 3'd5, 7'h2A, 1'b0, 3'd0, 3'd0, 3'd0, 3'd5, 7'h2A};
        vecs[2] = '{3'd7, 3'd7, 3'd0, 7'h7F, 1'b0, 3'd0, 3'd7, 3'd7, 3'd0, 7'h7F};
        // A changes one cycle after the press: still debouncing at commit, old value kept.
        vecs[3] = '{3'd2, 3'd4, 3'd1, 7'h01, 1'b1, 3'd6, 3'd2, 3'd4, 3'd1, 7'h01};

        rst = 1'b1;
        A_sw = '0; B_sw = '0; opcode_sw = '0; ctrl_sw = '0; load_btn = 1'b0;

        // Reset state, every reset cycle and the one after
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("reset_outputs", 32'(out_vec()), 32'h1);
        end
        rst = 1'b0;
        step(1);
        check("post_reset_outputs", 32'(out_vec()), 32'h1);

        // Basic commit latency and values
        A_sw = 3'b101; B_sw = 3'b011; opcode_sw = 3'b010;
        step(8);
        check("sw_stable_settled", 32'(sw_stable), 32'd1);
        p0 = pulses;
        load_btn = 1'b1;
        wait_pulse("basic_pulse", 20, lat);
        check("basic_latency", 32'(lat), 32'd7);
        check("basic_A", 32'(A_out), 32'd5);
        check("basic_B", 32'(B_out), 32'd3);
        check("basic_op", 32'(opcode_out), 32'd2);
        step(1);
        check("pulse_one_cycle", 32'(load_pulse), 32'd0);
        step(2);
        load_btn = 1'b0;
        step(30);
        check("basic_pulse_count", 32'(pulses - p0), 32'd1);

        // Table-driven commits
        for (int v = 0; v < 4; v++) begin
            A_sw = vecs[v].a; B_sw = vecs[v].b; opcode_sw = vecs[v].op; ctrl_sw = vecs[v].ctrl;
            step(8);
            p0 = pulses;
            load_btn = 1'b1;
            step(1);
            if (vecs[v].use_late) A_sw = vecs[v].late_a;
            wait_pulse($sformatf("vec%0d_pulse", v), 20, lat);
            check($sformatf("vec%0d_A", v), 32'(A_out), 32'(vecs[v].exp_a));
            check($sformatf("vec%0d_B", v), 32'(B_out), 32'(vecs[v].exp_b));
            check($sformatf("vec%0d_op", v), 32'(opcode_out), 32'(vecs[v].exp_op));
            check($sformatf("vec%0d_ctrl", v), 32'(ctrl_out), 32'(vecs[v].exp_ctrl));
            step(3);
            load_btn = 1'b0;
            step(30);
            check($sformatf("vec%0d_count", v), 32'(pulses - p0), 32'd1);
        end

        // Glitchy ctrl_sw[6] never flips the debounced value
        A_sw = '0; B_sw = '0; opcode_sw = '0; ctrl_sw = '0;
        step(10);
        ctrl_sw[6] = 1'b1; step(2);
        ctrl_sw[6] = 1'b0; step(2);
        check("glitch_sw_unstable", 32'(sw_stable), 32'd0);
        ctrl_sw[6] = 1'b1; step(2);
        ctrl_sw[6] = 1'b0; step(5);
        check("glitch_sw_stable_again", 32'(sw_stable), 32'd1);
        load_btn = 1'b1;
        wait_pulse("glitch_pulse", 20, lat);
        check("glitch_ctrl6", 32'(ctrl_out[6]), 32'd0);
        load_btn = 1'b0;
        step(30);

        // Bouncing button yields exactly one pulse
        p0 = pulses;
        for (int i = 0; i < 6; i++) begin
            load_btn = (i % 2 == 0);
            step(1);
        end
        load_btn = 1'b1;
        step(25);
        check("bounce_count", 32'(pulses - p0), 32'd1);

        // Re-press inside holdoff is ignored; after holdoff it commits once
        load_btn = 1'b0;
        step(7);
        p0 = pulses;
        load_btn = 1'b1;
        step(20);
        check("holdoff_ignored", 32'(pulses - p0), 32'd0);
        load_btn = 1'b0;
        step(30);
        p0 = pulses;
        load_btn = 1'b1;
        step(15);
        check("after_holdoff_count", 32'(pulses - p0), 32'd1);
        load_btn = 1'b0;
        step(30);

        // Button held across reset
        A_sw = 3'b111;
        load_btn = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("held_reset_outputs", 32'(out_vec()), 32'h1);
        end
        p0 = pulses;
        rst = 1'b0;
        wait_pulse("held_reset_pulse", 20, lat);
        check("held_reset_latency", 32'(lat), 32'd7);
        check("held_reset_A", 32'(A_out), 32'd7);
        step(30);
        check("held_reset_count", 32'(pulses - p0), 32'd1);
        load_btn = 1'b0;
        step(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
